l1_plru_tracker: RTL and testbench

- Per-set tree pseudo-LRU replacement tracker for a set-associative L1 cache (data or instruction).
- Pipeline accesses mark ways most-recently-used through a two-phase protocol: read on access, update on the next cycle.
- Cache fills request a victim way, which is returned one cycle later and is automatically marked MRU.

---
 rtl/l1_plru_tracker.sv | 85 ++++++++
 tb/tb_l1_plru_tracker.sv | 131 +++++++++++++
 2 files changed

// File: rtl/l1_plru_tracker.sv
// l1_plru_tracker: per-set tree pseudo-LRU victim selection with two-phase MRU updates
module l1_plru_tracker #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 64,
  localparam int SW = $clog2(NUM_SETS),
  localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fill_en,
  input  logic [SW-1:0] fill_set,
  output logic [WW-1:0] fill_way,
  input  logic          access_en,
  input  logic [SW-1:0] access_set,
  input  logic          update_en,
  input  logic [WW-1:0] update_way
);
  if (NUM_WAYS == 1) begin : g_one
    logic w_unused;
    assign w_unused = ^{clk, reset, fill_en, fill_set, access_en, access_set, update_en, update_way};
    assign fill_way = '0;
  end else begin : g_tree
    localparam int TB = NUM_WAYS - 1;
    localparam int NW = (TB > 1) ? $clog2(TB) : 1;
    localparam int L = $clog2(NUM_WAYS);
    logic [TB-1:0] r_tree [NUM_SETS];
    logic [TB-1:0] r_bits;
    logic [SW-1:0] r_set;
    logic          r_pfill;
    logic [SW-1:0] w_rset;
    logic          w_rd;
    logic          w_we;
    logic [WW-1:0] w_wway;
    logic [TB-1:0] w_wbits;
    logic [TB-1:0] w_rbits;
    function automatic logic [WW-1:0] victim(input logic [TB-1:0] b);
      logic [NW-1:0] n;
      logic [WW-1:0] w;
      n = '0;
      w = '0;
      for (int l = 0; l < L; l++) begin
        w = WW'({w, b[n]});
        n = NW'(2 * n + 1 + b[n]);
      end
      return w;
    endfunction
    // Each node on the path is pointed at the sibling subtree of the way just used.
    function automatic logic [TB-1:0] mru(input logic [TB-1:0] b, input logic [WW-1:0] way);
      logic [NW-1:0] n;
      logic [WW-1:0] w;
      logic          d;
      n = '0;
      w = way;
      for (int l = 0; l < L; l++) begin
        d = w[WW-1];
        b[n] = ~d;
        n = NW'(2 * n + 1 + d);
        w = w << 1;
      end
      return b;
    endfunction
    assign w_rd     = fill_en | access_en;
    assign w_rset   = fill_en ? fill_set : access_set;
    assign w_we     = r_pfill | update_en;
    assign w_wway   = r_pfill ? fill_way : update_way;
    assign w_wbits  = mru(r_tree[r_set], w_wway);
    assign w_rbits  = (w_we && r_set == w_rset) ? w_wbits : r_tree[w_rset];
    assign fill_way = victim(r_bits);
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_pfill <= 1'b0;
        r_set   <= '0;
        r_bits  <= '0;
        for (int s = 0; s < NUM_SETS; s++) r_tree[s] <= '0;
      end else begin
        r_pfill <= fill_en;
        if (w_rd) begin
          r_set  <= w_rset;
          r_bits <= w_rbits;
        end
        if (w_we) r_tree[r_set] <= w_wbits;
      end
    end
  end
endmodule

// File: tb/tb_l1_plru_tracker.sv
// tb_l1_plru_tracker: directed vectors for 4-way/16-set, 8-way and 1-way builds
module tb_l1_plru_tracker;
  logic       clk = 0;
  logic       reset = 1;
  logic       fill_en = 0, access_en = 0, update_en = 0;
  logic [3:0] fill_set = 0, access_set = 0;
  logic [1:0] update_way = 0;
  logic [1:0] fill_way;
  logic       f8_en = 0, zero = 0;
  logic [2:0] f8_set = 0, zero3 = 0;
  logic [2:0] way8;
  logic       way1;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  l1_plru_tracker #(.NUM_WAYS(4), .NUM_SETS(16)) dut (
    .clk(clk), .reset(reset), .fill_en(fill_en), .fill_set(fill_set), .fill_way(fill_way),
    .access_en(access_en), .access_set(access_set), .update_en(update_en), .update_way(update_way));
  l1_plru_tracker #(.NUM_WAYS(8), .NUM_SETS(8)) dut8 (
    .clk(clk), .reset(reset), .fill_en(f8_en), .fill_set(f8_set), .fill_way(way8),
    .access_en(zero), .access_set(zero3), .update_en(zero), .update_way(zero3));
  l1_plru_tracker #(.NUM_WAYS(1), .NUM_SETS(8)) dut1 (
    .clk(clk), .reset(reset), .fill_en(f8_en), .fill_set(f8_set), .fill_way(way1),
    .access_en(zero), .access_set(zero3), .update_en(zero), .update_way(zero));

  typedef struct {
    logic fe; logic [3:0] fs; logic ae; logic [3:0] as;
    logic ue; logic [1:0] uw; logic chk; logic [1:0] exp; string nm;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(logic fe, logic [3:0] fs, logic ae, logic [3:0] as,
                              logic ue, logic [1:0] uw, logic chk, logic [1:0] exp, string nm);
    vec_t v;
    v.fe = fe; v.fs = fs; v.ae = ae; v.as = as; v.ue = ue; v.uw = uw; v.chk = chk; v.exp = exp; v.nm = nm;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic fe, logic [3:0] fs, logic ae, logic [3:0] as, logic ue, logic [1:0] uw);
    fill_en = fe; fill_set = fs; access_en = ae; access_set = as; update_en = ue; update_way = uw;
  endtask

  initial begin
    tv.push_back(mk(1, 3, 0, 0, 0, 0, 1, 0, "fill3_a"));
    tv.push_back(mk(1, 3, 0, 0, 0, 0, 1, 2, "fill3_b"));
    tv.push_back(mk(1, 3, 0, 0, 0, 0, 1, 1, "fill3_c"));
    tv.push_back(mk(1, 3, 0, 0, 0, 0, 1, 3, "fill3_d"));
    tv.push_back(mk(1, 3, 0, 0, 0, 0, 1, 0, "fill3_e"));
    tv.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0, "acc5"));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, "upd5_w0"));
    tv.push_back(mk(1, 5, 0, 0, 0, 0, 1, 2, "fill5_a"));
    tv.push_back(mk(0, 0, 1, 5, 0, 0, 1, 1, "acc5_read"));
    tv.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, "upd5_w2"));
    tv.push_back(mk(1, 5, 0, 0, 0, 0, 1, 1, "fill5_b"));
    tv.push_back(mk(1, 4, 1, 6, 0, 0, 1, 0, "fill4_acc6"));
    tv.push_back(mk(0, 0, 0, 0, 1, 3, 1, 0, "upd_ignored_hold"));
    tv.push_back(mk(1, 6, 0, 0, 0, 0, 1, 0, "fill6"));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 1, 2, "fill4"));
    tv.push_back(mk(0, 0, 1, 9, 0, 0, 0, 0, "acc9"));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, "upd9_w1"));
    tv.push_back(mk(1, 10, 0, 0, 0, 0, 1, 0, "fill10"));
    tv.push_back(mk(1, 9, 0, 0, 0, 0, 1, 2, "fill9"));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, "idle_hold"));

    step();
    check("reset_way", fill_way, 0);
    check("reset_way8", way8, 0);
    reset = 0;
    step();
    check("post_reset_idle", fill_way, 0);

    foreach (tv[i]) begin
      drive(tv[i].fe, tv[i].fs, tv[i].ae, tv[i].as, tv[i].ue, tv[i].uw);
      step();
      if (tv[i].chk) check(tv[i].nm, fill_way, tv[i].exp);
    end

    drive(0, 0, 1, 3, 0, 0); step();
    drive(0, 0, 0, 0, 1, 2); step();
    drive(0, 0, 1, 3, 0, 0); step();
    drive(0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 1, 3, 0, 0); step();
    check("set3_before_reset", fill_way, 3);
    drive(0, 0, 0, 0, 1, 1);
    #2 reset = 1;
    #1 check("async_reset_way", fill_way, 0);
    step();
    reset = 0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 3, 0, 0, 0, 0); step(); check("rst_fill3_a", fill_way, 0);
    drive(1, 3, 0, 0, 0, 0); step(); check("rst_fill3_b", fill_way, 2);

    drive(1, 7, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    #2 reset = 1;
    #2 reset = 0;
    step();
    drive(1, 0, 0, 0, 0, 0); step(); check("pending_fill_dropped", fill_way, 0);
    drive(0, 0, 0, 0, 0, 0);

    begin
      logic [2:0] exp8 [5];
      exp8 = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1};
      for (int k = 0; k < 5; k++) begin
        f8_en = 1; f8_set = 0;
        step();
        check($sformatf("way8_fill%0d", k), way8, exp8[k]);
        check($sformatf("way1_fill%0d", k), way1, 0);
      end
      f8_en = 0;
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
